// File: rtl/if_stage_pc_ifid_pkg.sv
// Shared definitions for the RV32I fetch stage: bubble encoding, PC step and
// the fetch FSM state type.
package if_stage_pc_ifid_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_e;

  // Redirect targets are always word aligned.
  function automatic logic [31:0] align_target(input logic [31:0] target);
    return {target[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_pc_ifid_ifid_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, and a cycle
// without a completed fetch leaves a bubble. PC fields hold under a bubble.
module if_stage_pc_ifid_ifid_reg
  import if_stage_pc_ifid_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INSTR = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_plus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (flush_i) begin
      instr_d = BUBBLE_INSTR;
      valid_d = 1'b0;
    end else if (stall_i) begin
      valid_d = valid_q;
    end else if (!load_i) begin
      instr_d = BUBBLE_INSTR;
      valid_d = 1'b0;
    end else begin
      instr_d    = instr_i;
      pc_d       = pc_i;
      pc_plus4_d = pc_plus4_i;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q    <= BUBBLE_INSTR;
      pc_q       <= 32'd0;
      pc_plus4_q <= 32'd0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/if_stage_pc_ifid.sv
// RV32I fetch stage: PC, fetch FSM (BOOT/RUN/WAIT) and IF/ID register.
// Optional perf counters are enabled with the IF_PERF_CNT_EN macro.
module if_stage_pc_ifid
  import if_stage_pc_ifid_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = if_stage_pc_ifid_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] PCF,
  output logic [31:0] instrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic [1:0]  fetch_state_dbg,
  output logic        validD
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  // Handshake: imem_req is held high while a fetch is outstanding and the
  // address is stable; a fetch completes in any cycle with imem_req and
  // imem_ready both high, and imem_rdata is sampled in that same cycle.

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_plus4;
  logic         fetch_done;
  logic         ifid_flush;

  assign imem_req        = (state_q != ST_BOOT);
  assign imem_addr       = pc_q;
  assign PCF             = pc_q;
  assign pc_plus4        = pc_q + PC_STEP;
  assign fetch_done      = imem_req & imem_ready;
  assign ifid_flush      = FlushD | PCSrcE;
  assign fetch_state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN,
      ST_WAIT: state_d = (PCSrcE || imem_ready) ? ST_RUN : ST_WAIT;
      default: state_d = ST_BOOT;
    endcase
  end

  // A fetch discarded under StallF is simply reissued at the held PC.
  always_comb begin
    pc_d = pc_q;
    if (PCSrcE) begin
      pc_d = align_target(PCTargetE);
    end else if (!StallF && fetch_done) begin
      pc_d = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  if_stage_pc_ifid_ifid_reg #(
    .BUBBLE_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (ifid_flush),
    .stall_i    (StallD),
    .load_i     (fetch_done),
    .instr_i    (imem_rdata),
    .pc_i       (pc_q),
    .pc_plus4_i (pc_plus4),
    .instr_o    (instrD),
    .pc_o       (PCD),
    .pc_plus4_o (PCPlus4D),
    .valid_o    (validD)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_bubble_q, perf_bubble_d;

  // Flush bubbles are not counted; only real loads and not-ready/BOOT bubbles.
  always_comb begin
    perf_fetch_d  = perf_fetch_q;
    perf_bubble_d = perf_bubble_q;
    if (!ifid_flush && !StallD) begin
      if (fetch_done) begin
        if (perf_fetch_q != 32'hFFFF_FFFF) perf_fetch_d = perf_fetch_q + 32'd1;
      end else begin
        if (perf_bubble_q != 32'hFFFF_FFFF) perf_bubble_d = perf_bubble_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_q  <= 32'd0;
      perf_bubble_q <= 32'd0;
    end else begin
      perf_fetch_q  <= perf_fetch_d;
      perf_bubble_q <= perf_bubble_d;
    end
  end

  assign perf_fetch_cnt  = perf_fetch_q;
  assign perf_bubble_cnt = perf_bubble_q;
`endif

endmodule

// File: tb/tb_if_stage_pc_ifid.sv
// Bench for if_stage_pc_ifid: directed walk-through then random hazards,
// checked cycle by cycle against a behavioural model through a queue.
module tb_if_stage_pc_ifid;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int W = 130;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, StallF, StallD, FlushD, PCSrcE, imem_ready;
  logic [31:0] PCTargetE, data_key;
  logic        imem_req, validD;
  logic [31:0] imem_addr, imem_rdata, PCF, instrD, PCD, PCPlus4D;
  logic [1:0]  fetch_state_dbg;

  // instruction memory: word is a keyed function of its address
  assign imem_rdata = imem_addr ^ data_key;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
  logic [31:0] w_pf, w_pb;
`endif

  if_stage_pc_ifid dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .PCF(PCF), .instrD(instrD),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .fetch_state_dbg(fetch_state_dbg), .validD(validD)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  // second instance exercising PC wrap-around from the top of the address space
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_pcf, w_instr, w_pcd, w_pc4d;
  logic [1:0]  w_state;
  logic        w_zero = 1'b0;
  logic        w_one  = 1'b1;
  logic [31:0] w_tgt  = 32'd0;

  if_stage_pc_ifid #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .StallF(w_zero), .StallD(w_zero), .FlushD(w_zero),
    .PCSrcE(w_zero), .PCTargetE(w_tgt), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(w_addr), .imem_ready(w_one), .PCF(w_pcf), .instrD(w_instr),
    .PCD(w_pcd), .PCPlus4D(w_pc4d), .fetch_state_dbg(w_state), .validD(w_valid)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(w_pf), .perf_bubble_cnt(w_pb)
`endif
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [63:0]  exp_perf_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model of the fetch stage as seen at its outputs
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4, m_fetch, m_bubble;
  logic        m_boot, m_valid;

  task automatic tick();
    logic fetched;
    if (!rst_n) begin
      m_pc = 32'd0; m_boot = 1'b1; m_instr = NOP; m_pcd = 32'd0; m_pc4 = 32'd0;
      m_valid = 1'b0; m_fetch = 32'd0; m_bubble = 32'd0;
    end else begin
      fetched = !m_boot && imem_ready;
      if (FlushD || PCSrcE) begin
        m_instr = NOP; m_valid = 1'b0;
      end else if (!StallD) begin
        if (fetched) begin
          m_instr = m_pc ^ data_key; m_pcd = m_pc; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
          if (m_fetch != 32'hFFFF_FFFF) m_fetch = m_fetch + 32'd1;
        end else begin
          m_instr = NOP; m_valid = 1'b0;
          if (m_bubble != 32'hFFFF_FFFF) m_bubble = m_bubble + 32'd1;
        end
      end
      if (PCSrcE) m_pc = PCTargetE & 32'hFFFF_FFFC;
      else if (!StallF && fetched) m_pc = m_pc + 32'd4;
      m_boot = 1'b0;
    end
    exp_q.push_back({!m_boot, m_valid, m_pc, m_instr, m_pcd, m_pc4});
    exp_perf_q.push_back({m_fetch, m_bubble});
    @(posedge clk);
    #1;
  endtask

  // monitor: one expected snapshot per clock
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [63:0]  p;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      p = exp_perf_q.pop_front();
      chk("imem_req", {31'd0, imem_req}, {31'd0, e[129]});
      chk("validD",   {31'd0, validD},   {31'd0, e[128]});
      chk("PCF",      PCF,      e[127:96]);
      chk("imem_addr", imem_addr, e[127:96]);
      chk("instrD",   instrD,   e[95:64]);
      chk("PCD",      PCD,      e[63:32]);
      chk("PCPlus4D", PCPlus4D, e[31:0]);
`ifdef IF_PERF_CNT_EN
      chk("perf_fetch_cnt",  perf_fetch_cnt,  p[63:32]);
      chk("perf_bubble_cnt", perf_bubble_cnt, p[31:0]);
`endif
    end
  end

  initial begin
    rst_n = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    PCTargetE = 32'd0; imem_ready = 1'b1; data_key = 32'd0;
    tick(); tick();
    chk("wrap_reset_pcf", w_pcf, 32'hFFFF_FFFC);
    chk("wrap_reset_req", {31'd0, w_req}, 32'd0);

    // boot then streaming fetch with word = address
    rst_n = 1'b1;
    tick();
    chk("wrap_boot_pcf", w_pcf, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pcf", w_pcf, 32'h0000_0000);
    chk("wrap_pcd", w_pcd, 32'hFFFF_FFFC);
    chk("wrap_pc4d", w_pc4d, 32'h0000_0000);
    chk("wrap_instr", w_instr, 32'hFFFF_FFFC);
    for (int i = 0; i < 10 && m_pc != 32'h8; i++) tick();
    chk("stream_pcf", PCF, 32'h8);

    // slow memory: three not-ready cycles at PCF=0x8
    imem_ready = 1'b0;
    repeat (3) tick();
    chk("wait_pcf_hold", PCF, 32'h8);
    chk("wait_instr_nop", instrD, NOP);
    imem_ready = 1'b1;
    tick();
    chk("wait_done_instr", instrD, 32'h8);
    chk("wait_done_pc4", PCPlus4D, 32'hC);

    // redirect while waiting
    imem_ready = 1'b0;
    tick();
    chk("in_wait_state", {30'd0, fetch_state_dbg}, 32'd2);
    PCSrcE = 1'b1; PCTargetE = 32'h103;
    tick();
    PCSrcE = 1'b0;
    chk("redirect_pcf", PCF, 32'h100);
    chk("redirect_state", {30'd0, fetch_state_dbg}, 32'd1);
    chk("redirect_valid", {31'd0, validD}, 32'd0);
    imem_ready = 1'b1;
    tick();
    chk("redirect_pcd", PCD, 32'h100);

    // stall both, then flush under stall
    StallF = 1'b1; StallD = 1'b1;
    repeat (2) tick();
    chk("stall_pcf", PCF, 32'h104);
    FlushD = 1'b1;
    tick();
    chk("flush_over_stall", instrD, NOP);
    FlushD = 1'b0; StallF = 1'b0; StallD = 1'b0;

    // reset in the middle of a wait
    imem_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("midwait_reset_pcf", PCF, 32'd0);
    chk("midwait_reset_req", {31'd0, imem_req}, 32'd0);
    rst_n = 1'b1; imem_ready = 1'b1;

    // random hazards, redirects, memory latency and occasional reset
    data_key = $urandom;
    for (int i = 0; i < 3000; i++) begin
      rst_n      = ($urandom_range(0, 99) != 0);
      StallF     = ($urandom_range(0, 7) == 0);
      StallD     = StallF ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
      FlushD     = ($urandom_range(0, 11) == 0);
      PCSrcE     = ($urandom_range(0, 9) == 0);
      PCTargetE  = $urandom;
      imem_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst_n = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    imem_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage_pc_ifid.md
Name: if_stage_pc_ifid

Overview:
- Fetch stage of the 5-stage RV32I pipeline.
- Owns the program counter and addresses instruction memory.
- Holds the IF/ID pipeline register; its outputs instrD/PCD/PCPlus4D feed the decode field-extraction stage.
- Handles branch/jump redirect from Execute, hazard-unit stall and flush, and a memory-ready handshake so slow instruction memory inserts bubbles instead of corrupting the pipe.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction inserted into D (addi x0,x0,0).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- StallF  input  1  hazard unit: hold PC.
- StallD  input  1  hazard unit: hold IF/ID register.
- FlushD  input  1  hazard unit: bubble IF/ID register.
- PCSrcE  input  1  taken branch/jump resolved in Execute.
- PCTargetE  input  32  redirect target from Execute.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address (= PCF).
- imem_rdata  input  32  instruction word, valid when imem_ready=1 in the same cycle.
- imem_ready  input  1  memory returns imem_rdata this cycle.
- PCF  output  32  current fetch PC.
- instrD  output  32  IF/ID instruction.
- PCD  output  32  IF/ID PC.
- PCPlus4D  output  32  IF/ID PC+4.
- validD  output  1  IF/ID holds a real instruction.

Behaviour:
- One clock domain; reset synchronous, active-low, sampled on rising clk.
- Reset values (rst_n=0 at an edge):
  - PCF=RESET_PC; state=BOOT; imem_req=0.
  - instrD=NOP_INSTR; PCD=0; PCPlus4D=0; validD=0.
- Reset asserted mid-WAIT aborts the fetch; no stale rdata is captured.
- imem_addr = PCF, combinational. PCPlus4F = PCF+32'd4, modulo 2^32 (0xFFFFFFFC wraps to 0).
- Redirect target is {PCTargetE[31:2],2'b00}; low bits are always forced to zero.
- FSM states:
  - BOOT: imem_req=0; D loads bubble; always goes to RUN next cycle. PC holds, unless PCSrcE redirects.
  - RUN: imem_req=1. imem_ready=1 means the fetch completes; stay in RUN. imem_ready=0 goes to WAIT.
  - WAIT: imem_req=1 at unchanged PCF. imem_ready=1 means the fetch completes; go to RUN.
  - PCSrcE=1 in RUN or WAIT forces state RUN.
- Next-PC priority, highest first:
  1. reset.
  2. PCSrcE → redirect target.
  3. StallF → hold.
  4. BOOT or fetch not complete → hold.
  5. otherwise PCPlus4F.
- IF/ID register priority, highest first:
  1. reset.
  2. FlushD or PCSrcE → bubble (instrD=NOP_INSTR, validD=0, PCD/PCPlus4D hold).
  3. StallD → hold all.
  4. fetch not complete or BOOT → bubble.
  5. otherwise load imem_rdata, PCF, PCPlus4F; validD=1.
- Simultaneous events:
  - StallF=1 with imem_ready=1 and StallD=1: the fetch is discarded; the same PCF is refetched later. Memory is read-idempotent.
  - FlushD with StallD: flush wins.
  - PCSrcE with StallF: redirect wins.
- Latency: the instruction at PCF appears on instrD one edge after the cycle in which imem_ready=1.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[31:0] (increments on each IF/ID load with validD=1) and perf_bubble_cnt[31:0] (increments on each bubble load caused by a not-ready fetch or BOOT).
  - Both counters reset to 0, saturate at 0xFFFFFFFF, and hold during StallD.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - NOP_INSTR constant (32'h0000_0013);
  - fetch FSM state encoding (BOOT=2'd0, RUN=2'd1, WAIT=2'd2);
  - the PC_STEP=4 constant.
- One natural sub-module: ifid_reg. It is the IF/ID pipeline register with stall/flush/bubble priority and reset to bubble.
- PC logic and FSM live in the top.

Test Plan:
- Reset then imem_ready=1 constant, memory word=addr → after BOOT:
  - PCF steps 0,4,8 per cycle;
  - instrD=0x0,0x4,0x8 one cycle later;
  - validD=1 from the second post-boot cycle.
- imem_ready low for 3 cycles at PCF=0x8:
  - PCF holds 0x8;
  - validD=0 and instrD=0x13 for 3 cycles;
  - then instrD=0x8, PCPlus4D=0xC.
- PCSrcE=1, PCTargetE=0x103 while in WAIT:
  - next PCF=0x100, state RUN;
  - instrD bubble, validD=0;
  - next load PCD=0x100.
- StallF=StallD=1 for 2 cycles:
  - PCF and IF/ID hold;
  - FlushD=1 with StallD=1 → instrD=0x13, validD=0.
- RESET_PC=0xFFFFFFFC, ready=1 → PCF 0xFFFFFFFC then 0x00000000, PCPlus4D=0x0.
- rst_n=0 mid-WAIT → next edge PCF=RESET_PC, validD=0, imem_req=0. With IF_PERF_CNT_EN, both counters read 0.
